// File: rtl/fetch_barrel_pkg.sv
// ============================================================================
// Module   : fetch_barrel_pkg
// Brief    : Shared constants and helpers for the barrel-core fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_barrel_pkg;

    localparam int          DEF_ADDRESS_WIDTH = 32;
    localparam int          DEF_DATA_WIDTH    = 32;
    localparam int          DEF_NUM_THREADS   = 8;
    localparam int          DEF_BITS_THREADS  = $clog2(DEF_NUM_THREADS);
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;

    // Thread index reached by stepping 'off' places past 'base', wrapping at n.
    function automatic int wrap_tid(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_barrel_rr_thread_arbiter.sv
// ============================================================================
// Module   : rr_thread_arbiter
// Brief    : Combinational round-robin pick of the next enabled thread.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_thread_arbiter
    import fetch_barrel_pkg::*;
#(
    parameter int NUM_THREADS  = DEF_NUM_THREADS,
    parameter int BITS_THREADS = $clog2(NUM_THREADS)
) (
    input  logic [NUM_THREADS-1:0]  thread_en,
    input  logic [BITS_THREADS-1:0] last_tid,
    output logic [BITS_THREADS-1:0] sel,
    output logic                    any_en
);

    logic                    w_found;
    logic [BITS_THREADS-1:0] w_idx;

    assign any_en = |thread_en;

    // Scan starts one past the last issued thread so every enabled thread gets a turn.
    always_comb begin
        sel     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            w_idx = BITS_THREADS'(wrap_tid(int'(last_tid), i + 1, NUM_THREADS));
            if (!w_found && thread_en[w_idx]) begin
                sel     = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_barrel.sv
// ============================================================================
// Module   : fetch_barrel
// Brief    : Barrel-core fetch stage: per-thread PCs, round-robin issue to a
//            synchronous instruction memory, execute-stage redirects.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_barrel
    import fetch_barrel_pkg::*;
#(
    parameter int                         ADDRESS_WIDTH    = DEF_ADDRESS_WIDTH,
    parameter int                         DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int                         NUM_THREADS      = DEF_NUM_THREADS,
    parameter int                         BITS_THREADS     = $clog2(NUM_THREADS),
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC         = '0,
    parameter logic [ADDRESS_WIDTH-1:0]   THREAD_PC_STRIDE = ADDRESS_WIDTH'(32'h100)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_f,
    input  logic [NUM_THREADS-1:0]   thread_en,
    input  logic                     pc_src_e,
    input  logic [BITS_THREADS-1:0]  tid_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic [ADDRESS_WIDTH-1:0] pc_f,
    output logic [DATA_WIDTH-1:0]    instr_f,
    output logic [BITS_THREADS-1:0]  tid_f,
    output logic                     valid_f
);

    logic [ADDRESS_WIDTH-1:0] r_pc [NUM_THREADS];
    logic [BITS_THREADS-1:0]  r_last_tid;
    logic [BITS_THREADS-1:0]  r_tid_f;
    logic [ADDRESS_WIDTH-1:0] r_pc_f;
    logic [ADDRESS_WIDTH-1:0] r_imem_addr;
    logic                     r_issue_v;

    logic [BITS_THREADS-1:0]  w_sel;
    logic                     w_any_en;
    logic                     w_issue;

    rr_thread_arbiter #(
        .NUM_THREADS  (NUM_THREADS),
        .BITS_THREADS (BITS_THREADS)
    ) u_arbiter (
        .thread_en (thread_en),
        .last_tid  (r_last_tid),
        .sel       (w_sel),
        .any_en    (w_any_en)
    );

    assign w_issue = !stall_f && w_any_en;

    // Holding the address while idle or stalled keeps imem re-reading the word on display.
    assign imem_addr = (rst_n && w_issue) ? r_pc[w_sel] : r_imem_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_pc[t] <= RESET_PC + ADDRESS_WIDTH'(t) * THREAD_PC_STRIDE;
            end
            r_last_tid  <= BITS_THREADS'(NUM_THREADS - 1);
            r_tid_f     <= '0;
            r_pc_f      <= '0;
            r_imem_addr <= '0;
            r_issue_v   <= 1'b0;
        end else begin
            // A redirect overrides the increment when both hit the same thread.
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (pc_src_e && tid_e == BITS_THREADS'(t)) begin
                    r_pc[t] <= pc_target_e;
                end else if (w_issue && w_sel == BITS_THREADS'(t)) begin
                    r_pc[t] <= r_pc[t] + ADDRESS_WIDTH'(4);
                end
            end
            if (w_issue) begin
                r_last_tid  <= w_sel;
                r_tid_f     <= w_sel;
                r_pc_f      <= r_pc[w_sel];
                r_imem_addr <= r_pc[w_sel];
                r_issue_v   <= 1'b1;
            end else if (!stall_f) begin
                r_issue_v   <= 1'b0;
            end
        end
    end

    assign pc_f    = r_pc_f;
    assign tid_f   = r_tid_f;
    assign valid_f = r_issue_v;
    assign instr_f = r_issue_v ? imem_rdata : DATA_WIDTH'(NOP_INSTR);

endmodule

`default_nettype wire

// File: tb/tb_fetch_barrel.sv
// ============================================================================
// Module   : tb_fetch_barrel
// Brief    : Directed self-checking bench for fetch_barrel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_barrel;

    localparam logic [31:0] C_NOP  = 32'h0000_0013;
    localparam logic [31:0] C_SALT = 32'hA500_0000;

    logic        clk;
    logic        rst_n;
    logic        stall_f;
    logic [7:0]  thread_en;
    logic        pc_src_e;
    logic [2:0]  tid_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_f;
    logic [2:0]  tid_f;
    logic        valid_f;

    int total;
    int bad;

    fetch_barrel dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_f     (stall_f),
        .thread_en   (thread_en),
        .pc_src_e    (pc_src_e),
        .tid_e       (tid_e),
        .pc_target_e (pc_target_e),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .pc_f        (pc_f),
        .instr_f     (instr_f),
        .tid_f       (tid_f),
        .valid_f     (valid_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous imem: each word's content is its address XOR a salt.
    initial imem_rdata = '0;
    always @(posedge clk) imem_rdata <= imem_addr ^ C_SALT;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic fetch_chk(input string tag, input logic [31:0] tid, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'b0, valid_f}, 32'd1);
        chk({tag, "_tid"},   {29'b0, tid_f},   tid);
        chk({tag, "_pc"},    pc_f,             pc);
        chk({tag, "_instr"}, instr_f,          pc ^ C_SALT);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t2_tid [8] = '{4, 5, 6, 7, 0, 1, 2, 3};
    logic [31:0] t2_pc  [8] = '{32'h404, 32'h504, 32'h604, 32'h704,
                                32'h008, 32'h108, 32'h208, 32'h2004};

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0; stall_f = 1'b0; thread_en = 8'hFF;
        pc_src_e = 1'b0; tid_e = '0; pc_target_e = '0;

        // Reset state
        step(); step();
        chk("rst_valid", {31'b0, valid_f}, 32'd0);
        chk("rst_instr", instr_f, C_NOP);
        chk("rst_pc",    pc_f, 32'h0);
        chk("rst_tid",   {29'b0, tid_f}, 32'd0);
        chk("rst_imem",  imem_addr, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("t1_addr", imem_addr, 32'h0);

        // Full round-robin over eight threads, then wrap to thread 0 at PC+4
        for (int i = 0; i < 8; i++) begin
            step();
            fetch_chk("t1_rr", i, i * 32'h100);
        end
        step();
        fetch_chk("t1_wrap", 0, 32'h004);

        // Redirect thread 3 while thread 1 issues
        pc_src_e = 1'b1; tid_e = 3'd3; pc_target_e = 32'h2000;
        step();
        fetch_chk("t2_a", 1, 32'h104);
        pc_src_e = 1'b0;
        step(); fetch_chk("t2_b", 2, 32'h204);
        step(); fetch_chk("t2_tgt", 3, 32'h2000);
        for (int i = 0; i < 8; i++) begin
            step();
            fetch_chk("t2_seq", t2_tid[i], t2_pc[i]);
        end

        // Only thread 3 enabled; redirect collides with its own increment
        thread_en = 8'h08;
        step(); fetch_chk("t3_a", 3, 32'h2008);
        pc_src_e = 1'b1; tid_e = 3'd3; pc_target_e = 32'h40;
        step(); fetch_chk("t3_b", 3, 32'h200C);
        pc_src_e = 1'b0;
        step(); fetch_chk("t3_win", 3, 32'h40);
        step(); fetch_chk("t3_next", 3, 32'h44);

        // Mid-run reset, then sparse mask 0010_0101
        rst_n = 1'b0; thread_en = 8'b0010_0101;
        step();
        chk("t6_valid", {31'b0, valid_f}, 32'd0);
        chk("t6_instr", instr_f, C_NOP);
        rst_n = 1'b1;
        step(); fetch_chk("t4_a", 0, 32'h000);
        step(); fetch_chk("t4_b", 2, 32'h200);
        step(); fetch_chk("t4_c", 5, 32'h500);
        step(); fetch_chk("t4_d", 0, 32'h004);

        // All threads disabled: bubbles, PCs held
        thread_en = 8'h00;
        #1;
        chk("t4_hold_addr", imem_addr, 32'h004);
        step();
        chk("t4_idle_valid", {31'b0, valid_f}, 32'd0);
        chk("t4_idle_instr", instr_f, C_NOP);
        step();
        chk("t4_idle_valid2", {31'b0, valid_f}, 32'd0);
        thread_en = 8'b0010_0101;
        step(); fetch_chk("t4_resume2", 2, 32'h204);
        step(); fetch_chk("t4_resume5", 5, 32'h504);

        // Stall for three cycles with a redirect of thread 7 landing during the stall
        thread_en = 8'hFF;
        step(); fetch_chk("t5_pre", 6, 32'h600);
        stall_f = 1'b1; pc_src_e = 1'b1; tid_e = 3'd7; pc_target_e = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            step();
            pc_src_e = 1'b0;
            fetch_chk("t5_stall", 6, 32'h600);
            chk("t5_stall_addr", imem_addr, 32'h600);
        end
        stall_f = 1'b0;
        #1;
        chk("t5_rel_addr", imem_addr, 32'h3000);
        step(); fetch_chk("t5_rel", 7, 32'h3000);
        step(); fetch_chk("t5_next", 0, 32'h008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
